// File: rtl/balance_display.sv
// Display end of the scale datapath: shift-add-3 price conversion plus a
// multiplexed common-anode 7-segment scan that alternates weight and price pages.
//
//   state | meaning
//   IDLE  | waiting for a load strobe; display registers hold the last commit
//   CONV  | one shift-add-3 iteration per cycle, commit after the 10th
module balance_display #(
  parameter int REFRESH_DIV = 16,
  parameter int PAGE_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic [6:0] bcd_weight,
  input  logic [9:0] price,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       page,
  output logic       busy
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int PW = (PAGE_CYCLES > 2) ? $clog2(PAGE_CYCLES) : 1;
  localparam logic [RW-1:0] REF_TC  = RW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PAGE_TC = PW'(PAGE_CYCLES - 1);

  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_q, state_d;
  logic        load, last_iter;
  logic [3:0]  iter_q;
  logic [11:0] bcd_q, bcd_adj, bcd_next;
  logic [9:0]  bin_q;
  logic [6:0]  weight_q;
  logic        ovf_q;

  logic [2:0]  w_tens;
  logic [3:0]  w_units, p_hund, p_tens, p_units;
  logic        ovf_disp;

  logic [RW-1:0] ref_cnt;
  logic [PW-1:0] page_cnt;
  logic [1:0]    idx_q;
  logic          page_q;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_DASH;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    last_iter = 1'b0;
    case (state_q)
      IDLE: if (data_valid) begin
        load    = 1'b1;
        state_d = CONV;
      end
      CONV: if (iter_q == 4'd9) begin
        last_iter = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int n = 0; n < 3; n++)
      if (bcd_q[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
    bcd_next = (bcd_adj << 1) | {11'd0, bin_q[9]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      iter_q   <= '0;
      bcd_q    <= '0;
      bin_q    <= '0;
      weight_q <= '0;
      ovf_q    <= 1'b0;
      w_tens   <= '0;
      w_units  <= '0;
      p_hund   <= '0;
      p_tens   <= '0;
      p_units  <= '0;
      ovf_disp <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        weight_q <= bcd_weight;
        bin_q    <= price;
        ovf_q    <= (price > 10'd999);
        bcd_q    <= '0;
        iter_q   <= '0;
      end else if (state_q == CONV) begin
        bcd_q  <= bcd_next;
        bin_q  <= bin_q << 1;
        iter_q <= iter_q + 4'd1;
      end
      // All display fields change on the same edge so the scan never mixes loads
      if (last_iter) begin
        w_tens   <= weight_q[6:4];
        w_units  <= weight_q[3:0];
        p_hund   <= bcd_next[11:8];
        p_tens   <= bcd_next[7:4];
        p_units  <= bcd_next[3:0];
        ovf_disp <= ovf_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt  <= '0;
      page_cnt <= '0;
      idx_q    <= '0;
      page_q   <= 1'b0;
    end else begin
      if (ref_cnt == REF_TC) begin
        ref_cnt <= '0;
        idx_q   <= idx_q + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      if (page_cnt == PAGE_TC) begin
        page_cnt <= '0;
        page_q   <= ~page_q;
      end else begin
        page_cnt <= page_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    seg_d = SEG_BLANK;
    if (!page_q) begin
      case (idx_q)
        2'd0:    seg_d = digit_seg(w_units);
        2'd1:    if (w_tens != 3'd0) seg_d = digit_seg({1'b0, w_tens});
        default: seg_d = SEG_BLANK;
      endcase
    end else begin
      case (idx_q)
        2'd3:    seg_d = SEG_P;
        2'd2:    seg_d = ovf_disp ? SEG_E : digit_seg(p_hund);
        2'd1:    seg_d = ovf_disp ? SEG_E : digit_seg(p_tens);
        default: seg_d = ovf_disp ? SEG_E : digit_seg(p_units);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= SEG_ZERO;
      an_q  <= 4'b1110;
    end else begin
      seg_q <= seg_d;
      an_q  <= ~(4'b0001 << idx_q);
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign page = page_q;
  assign busy = (state_q == CONV);

endmodule

// File: tb/tb_balance_display.sv
// Randomized bench for balance_display; expected scan, page, busy and segment
// values come from a cycle-count model using decimal arithmetic on the loads.
module tb_balance_display;

  localparam logic [6:0] S_P     = 7'b0001100;
  localparam logic [6:0] S_E     = 7'b0000110;
  localparam logic [6:0] S_DASH  = 7'b0111111;
  localparam logic [6:0] S_BLANK = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data_valid = 1'b0;
  logic [6:0] bcd_weight = '0;
  logic [9:0] price = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       page, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int t, busy_left, pend_w, pend_p, disp_w, disp_p;

  balance_display #(.REFRESH_DIV(4), .PAGE_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .bcd_weight(bcd_weight),
    .price(price), .seg(seg), .an(an), .page(page), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] code(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return S_DASH;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg_of(int pg, int idx, int w, int p);
    int tens = w / 16;
    int units = w % 16;
    if (pg == 0) begin
      if (idx == 0) return code(units);
      if (idx == 1) return (tens == 0) ? S_BLANK : code(tens);
      return S_BLANK;
    end
    if (idx == 3) return S_P;
    if (p > 999) return S_E;
    if (idx == 2) return code(p / 100);
    if (idx == 1) return code((p / 10) % 10);
    return code(p % 10);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    busy_left = 0;
    disp_w = 0;
    disp_p = 0;
  endtask

  task automatic check_reset(string tag);
    check({tag, "_an"},   32'(an),   32'h0000_000e);
    check({tag, "_seg"},  32'(seg),  32'h0000_0040);
    check({tag, "_page"}, 32'(page), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // One clock: model the edge from pre-edge state, then compare just after it.
  task automatic tick();
    int idx, pg;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    idx   = (t / 4) % 4;
    pg    = (t / 64) % 2;
    e_an  = ~(4'b0001 << idx);
    e_seg = exp_seg_of(pg, idx, disp_w, disp_p);
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        disp_w = pend_w;
        disp_p = pend_p;
      end
    end else if (data_valid) begin
      pend_w    = int'(bcd_weight);
      pend_p    = int'(price);
      busy_left = 10;
    end
    t++;
    @(posedge clk);
    #1;
    check("an",   32'(an),   32'(e_an));
    check("seg",  32'(seg),  32'(e_seg));
    check("page", 32'(page), 32'((t / 64) % 2));
    check("busy", 32'(busy), 32'(busy_left > 0));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load(logic [6:0] w, logic [9:0] p);
    data_valid = 1'b1;
    bcd_weight = w;
    price      = p;
    tick();
    data_valid = 1'b0;
  endtask

  initial begin
    int corners[4] = '{999, 0, 1000, 1023};
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset("rst_hold");
    end
    rst = 1'b1;
    run(140);

    load(7'h12, 10'd240);
    run(140);

    foreach (corners[k]) begin
      load(7'($urandom_range(0, 127)), 10'(corners[k]));
      run(140);
    end

    load(7'h34, 10'd321);
    run(2);
    load(7'h00, 10'd5);
    run(140);

    load(7'h07, 10'd500);
    run(140);
    load(7'h0A, 10'd123);
    run(140);

    load(7'h55, 10'd876);
    run(5);
    #2 rst = 1'b0;
    #1 check_reset("async_rst");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset("async_hold");
    end
    model_reset();
    rst = 1'b1;
    run(140);

    repeat (600) begin
      data_valid = ($urandom_range(0, 24) == 0);
      bcd_weight = 7'($urandom);
      price      = 10'($urandom);
      tick();
    end
    data_valid = 1'b0;
    run(140);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
